rect_slot_sched: RTL
====================

# rect_slot_sched

Arbitrates rectangle updates from several detection engines into a fixed table of rectangle slots. Commits the table atomically once per video frame and ages out stale slots. Sits between the detection/recognition stages and the rectangle-overlay stage of the post-processing chain. Drives the overlay's packed rectangle bus so the overlay never sees a table that changes mid-frame.

## Interface
- REQ_N, 4, number of requesters (2..8)
- RECT_NUMMAX, `RECT_NUMMAX` (8), number of rectangle slots (power of 2, ≤16)
- S_W, 4, slot-index width (≥ log2(RECT_NUMMAX)+1, so out-of-range indices are expressible)
- FRAME_X / FRAME_Y, `OV5640_X` / `OV5640_Y`, active pixels per line / lines per frame
- P_W, `POSITION_WIDTH`, pixel counter width
- AGE_MAX, 3, number of committed frames without refresh before a slot is dropped (1..15)

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset (asynchronous, active-low)
- i_valid  in  1  pixel strobe of the video stream feeding the overlay
- req_valid  in  REQ_N  per-requester write request
- req_slot  in  REQ_N*S_W  target slot index per requester
- req_rect  in  REQ_N*32  rectangle per requester: [31:24] x_min, [23:16] y_min, [15:8] x_max, [7:0] y_max, in 4-pixel units
- req_ready  out  REQ_N  grant; a transfer occurs when req_valid&req_ready
- o_item  out  RECT_NUMMAX*32  committed rectangle table, slot k at [32k +: 32]
- o_item_mask  out  RECT_NUMMAX  committed slot-valid bits
- o_frame_start  out  1  one-cycle pulse in the cycle after a commit
- o_drop_cnt  out  8  saturating count of dropped requests

## Operation
- **Frame counter.** Internal cnt_x/cnt_y advance on i_valid. cnt_x wraps at FRAME_X-1; cnt_y increments at the wrap and wraps at FRAME_Y-1.
- **Commit event.** i_valid=1 with cnt_x=FRAME_X-1 and cnt_y=FRAME_Y-1, i.e. the last pixel of the frame.
- **Arbiter.** Round-robin with one grant per cycle.
  - req_ready is combinational: at most one bit set, namely the first requester with req_valid=1 searching from pointer ptr upward (wrapping).
  - After a grant to requester g, ptr becomes (g+1) mod REQ_N. With no grant, ptr holds.
  - In the commit cycle, req_ready is all zeros.
- **Shadow table.** Each slot holds rect, valid, age (4 bit) and a refreshed flag.
- **Accepted write to slot s < RECT_NUMMAX:**
  - if x_min ≤ x_max and y_min ≤ y_max: rect ← req_rect, valid ← 1, age ← 0, refreshed ← 1.
  - otherwise: valid ← 0, age ← 0. This is the explicit delete.
- **Accepted write with s ≥ RECT_NUMMAX:** discarded; o_drop_cnt increments, saturating at 255.
- **At commit, for each slot:**
  - not refreshed and valid: age ← age+1. If the new age equals AGE_MAX, valid ← 0.
  - refreshed cleared for all slots.
  - o_item[k] ← rect if the post-aging valid=1, else 32'h FFFF_0000 (x_min > x_max, so the overlay never matches).
  - o_item_mask[k] ← post-aging valid.
- **Stability.** o_item and o_item_mask change only on commit edges.

## Timing
- **Reset values:**
  - o_item: every slot 32'h FFFF_0000
  - o_item_mask, o_frame_start, o_drop_cnt: 0
  - ptr, cnt_x, cnt_y: 0
  - shadow valid/age/refreshed: 0
- **Write latency.** A write accepted at edge n is visible in the shadow table after edge n. It reaches o_item at the next commit edge.
- **o_frame_start** is high for exactly the cycle following the commit edge.
- **Same-slot collisions.** Two requests to the same slot in consecutive cycles: the later grant wins.
- **Held requests.** A requester may hold req_valid across the commit stall. Its request is granted on a later cycle, not lost.
- **Reset mid-frame.** All state returns to reset values. The first commit after reset occurs after a full FRAME_X×FRAME_Y i_valid pulses.
- **i_valid gaps.** Gaps of any length do not affect the counter or commit timing, apart from delaying the commit.

## Test plan
1. **Reset.** Reset, then check every output.
   - Expect o_item=all 32'hFFFF_0000, o_item_mask=0, o_drop_cnt=0.
2. **Round-robin order.** Requesters 0..3 all valid continuously, ptr=0.
   - Expect grant order 0,1,2,3,0.
   - During the commit cycle, req_ready=0.
3. **Write then commit.** Requester 1 writes slot 2 with 32'h10_20_30_40 mid-frame.
   - o_item unchanged until the commit edge.
   - After commit: o_item[2]=32'h10203040, o_item_mask=8'b0000_0100, o_frame_start pulses once.
4. **Aging, AGE_MAX=3.** Write slot 5 once, then no refresh.
   - Mask bit 5 stays 1 after the first and second commits without refresh.
   - After the third commit without refresh: mask bit 5=0 and o_item[5]=32'hFFFF_0000.
5. **Delete and drop.** Write slot 0 with 32'h30_00_10_00 (x_min > x_max); separately write slot 9 with RECT_NUMMAX=8.
   - After commit: slot 0 invalid.
   - o_drop_cnt=1.
   - 300 writes to slot 9: o_drop_cnt saturates at 255.
6. **Reset mid-frame.** Assert reset mid-frame with pending writes.
   - Expect all outputs back to reset values.
   - Commit occurs exactly FRAME_X*FRAME_Y i_valid pulses after release.

Source files
------------

// File: rtl/rect_slot_sched.sv
// rect_slot_sched: round-robin arbitration of rectangle writes into a shadow
// slot table, committed atomically to the overlay once per video frame,
// with per-slot aging of rectangles that stop being refreshed.

`ifndef RECT_NUMMAX
`define RECT_NUMMAX 8
`endif
`ifndef OV5640_X
`define OV5640_X 640
`endif
`ifndef OV5640_Y
`define OV5640_Y 480
`endif
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 12
`endif

module rect_slot_sched #(
  parameter int unsigned REQ_N       = 4,
  parameter int unsigned RECT_NUMMAX = `RECT_NUMMAX,
  parameter int unsigned S_W         = 4,
  parameter int unsigned FRAME_X     = `OV5640_X,
  parameter int unsigned FRAME_Y     = `OV5640_Y,
  parameter int unsigned P_W         = `POSITION_WIDTH,
  parameter int unsigned AGE_MAX     = 3
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      i_valid,
  input  logic [REQ_N-1:0]          req_valid,
  input  logic [REQ_N*S_W-1:0]      req_slot,
  input  logic [REQ_N*32-1:0]       req_rect,
  output logic [REQ_N-1:0]          req_ready,
  output logic [RECT_NUMMAX*32-1:0] o_item,
  output logic [RECT_NUMMAX-1:0]    o_item_mask,
  output logic                      o_frame_start,
  output logic [7:0]                o_drop_cnt
);

  localparam int unsigned PTR_W = $clog2(REQ_N);
  localparam int unsigned SI_W  = $clog2(RECT_NUMMAX);
  localparam logic [31:0] EMPTY_RECT = 32'hFFFF_0000;

  // Registered state
  logic [P_W-1:0]                cnt_x_q, cnt_x_d;
  logic [P_W-1:0]                cnt_y_q, cnt_y_d;
  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [31:0]                   rect_q [RECT_NUMMAX];
  logic [31:0]                   rect_d [RECT_NUMMAX];
  logic [3:0]                    age_q  [RECT_NUMMAX];
  logic [3:0]                    age_d  [RECT_NUMMAX];
  logic [RECT_NUMMAX-1:0]        valid_q, valid_d;
  logic [RECT_NUMMAX-1:0]        refr_q, refr_d;
  logic [RECT_NUMMAX*32-1:0]     item_q, item_d;
  logic [RECT_NUMMAX-1:0]        mask_q, mask_d;
  logic                          fs_q, fs_d;
  logic [7:0]                    drop_q, drop_d;

  // Combinational helpers
  logic                          last_x_c, last_y_c, commit_c;
  logic                          gnt_vld_c;
  logic [PTR_W-1:0]              gnt_idx_c;
  logic [PTR_W:0]                arb_sum_c;
  logic [PTR_W-1:0]              arb_idx_c;
  logic                          wr_en_c, wr_in_range_c, wr_ok_c;
  logic [S_W-1:0]                wr_slot_c;
  logic [SI_W-1:0]               wr_idx_c;
  logic [31:0]                   wr_rect_c;

  // Frame position counter; commit on the last pixel of the frame
  always_comb begin
    last_x_c = (cnt_x_q == P_W'(FRAME_X - 1));
    last_y_c = (cnt_y_q == P_W'(FRAME_Y - 1));
    commit_c = i_valid & last_x_c & last_y_c;
    cnt_x_d  = cnt_x_q;
    cnt_y_d  = cnt_y_q;
    if (i_valid) begin
      if (last_x_c) begin
        cnt_x_d = '0;
        cnt_y_d = last_y_c ? '0 : cnt_y_q + 1'b1;
      end else begin
        cnt_x_d = cnt_x_q + 1'b1;
      end
    end
  end

  // Round-robin search from ptr; descending loop so the nearest requester wins
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    arb_sum_c = '0;
    arb_idx_c = '0;
    for (int i = int'(REQ_N) - 1; i >= 0; i--) begin
      arb_sum_c = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (arb_sum_c >= (PTR_W+1)'(REQ_N)) arb_sum_c = arb_sum_c - (PTR_W+1)'(REQ_N);
      arb_idx_c = arb_sum_c[PTR_W-1:0];
      if (req_valid[arb_idx_c]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = arb_idx_c;
      end
    end
  end

  // Grant is withheld in the commit cycle so writes never race the commit
  always_comb begin
    req_ready = '0;
    if (gnt_vld_c && !commit_c) req_ready[gnt_idx_c] = 1'b1;
  end

  // Decode the granted request
  always_comb begin
    wr_en_c       = gnt_vld_c & ~commit_c;
    wr_slot_c     = req_slot[gnt_idx_c*S_W +: S_W];
    wr_rect_c     = req_rect[gnt_idx_c*32 +: 32];
    wr_idx_c      = wr_slot_c[SI_W-1:0];
    wr_in_range_c = (wr_slot_c < S_W'(RECT_NUMMAX));
    wr_ok_c       = (wr_rect_c[31:24] <= wr_rect_c[15:8]) &&
                    (wr_rect_c[23:16] <= wr_rect_c[7:0]);
  end

  // Shadow table update on writes; aging and output snapshot on commit
  always_comb begin
    ptr_d   = ptr_q;
    rect_d  = rect_q;
    age_d   = age_q;
    valid_d = valid_q;
    refr_d  = refr_q;
    item_d  = item_q;
    mask_d  = mask_q;
    drop_d  = drop_q;
    fs_d    = commit_c;

    if (wr_en_c) begin
      ptr_d = (gnt_idx_c == PTR_W'(REQ_N - 1)) ? '0 : gnt_idx_c + 1'b1;
      if (wr_in_range_c) begin
        age_d[wr_idx_c] = 4'd0;
        if (wr_ok_c) begin
          rect_d[wr_idx_c]  = wr_rect_c;
          valid_d[wr_idx_c] = 1'b1;
          refr_d[wr_idx_c]  = 1'b1;
        end else begin
          // inverted bounds act as an explicit delete
          valid_d[wr_idx_c] = 1'b0;
        end
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end

    if (commit_c) begin
      for (int k = 0; k < int'(RECT_NUMMAX); k++) begin
        if (!refr_q[k] && valid_q[k]) begin
          age_d[k] = age_q[k] + 4'd1;
          if ((age_q[k] + 4'd1) == 4'(AGE_MAX)) valid_d[k] = 1'b0;
        end
        refr_d[k]          = 1'b0;
        mask_d[k]          = valid_d[k];
        item_d[k*32 +: 32] = valid_d[k] ? rect_q[k] : EMPTY_RECT;
      end
    end
  end

  // State registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      ptr_q   <= '0;
      for (int k = 0; k < int'(RECT_NUMMAX); k++) begin
        rect_q[k] <= '0;
        age_q[k]  <= '0;
      end
      valid_q <= '0;
      refr_q  <= '0;
      item_q  <= {RECT_NUMMAX{EMPTY_RECT}};
      mask_q  <= '0;
      fs_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      ptr_q   <= ptr_d;
      rect_q  <= rect_d;
      age_q   <= age_d;
      valid_q <= valid_d;
      refr_q  <= refr_d;
      item_q  <= item_d;
      mask_q  <= mask_d;
      fs_q    <= fs_d;
      drop_q  <= drop_d;
    end
  end

  assign o_item        = item_q;
  assign o_item_mask   = mask_q;
  assign o_frame_start = fs_q;
  assign o_drop_cnt    = drop_q;

endmodule
